// File: rtl/s_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module  : s_cla_pipe_adder
// Brief   : Pipelined signed carry-lookahead adder/subtractor, one BLOCK-bit
//           lookahead group per stage, valid/ready on both sides.
// Revision: 1.0  initial release
// ============================================================================
module s_cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int L = WIDTH / BLOCK;

    // Returns {group carry-out, group sum}; every carry is expanded directly
    // from generate/propagate terms and the group carry-in (no internal ripple).
    function automatic logic [BLOCK:0] f_cla(
        input logic [BLOCK-1:0] i_ga,
        input logic [BLOCK-1:0] i_gb,
        input logic             i_ci
    );
        logic [BLOCK-1:0] w_p;
        logic [BLOCK-1:0] w_g;
        logic [BLOCK:0]   w_c;
        logic             w_run;
        w_p    = i_ga | i_gb;
        w_g    = i_ga & i_gb;
        w_c    = '0;
        w_c[0] = i_ci;
        for (int i = 0; i < BLOCK; i++) begin
            w_run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_run & w_g[j]);
                w_run    = w_run & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_run & i_ci);
        end
        return {w_c[BLOCK], i_ga ^ i_gb ^ w_c[BLOCK-1:0]};
    endfunction

    logic w_en;

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_s_in;
        logic             w_c_in;
        logic             w_v_in;
        logic [BLOCK:0]   w_grp;
        logic [WIDTH-1:0] w_s_nxt;

        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_s;
        logic             r_c;
        logic             r_v;

        if (k == 0) begin : g_head
            // Subtraction folds into the adder: invert b here, carry-in of 1.
            assign w_a_in = a;
            assign w_b_in = b ^ {WIDTH{sub}};
            assign w_s_in = '0;
            assign w_c_in = sub;
            assign w_v_in = in_valid;
        end else begin : g_body
            assign w_a_in = g_stage[k-1].r_a;
            assign w_b_in = g_stage[k-1].r_b;
            assign w_s_in = g_stage[k-1].r_s;
            assign w_c_in = g_stage[k-1].r_c;
            assign w_v_in = g_stage[k-1].r_v;
        end

        assign w_grp = f_cla(w_a_in[k*BLOCK +: BLOCK], w_b_in[k*BLOCK +: BLOCK], w_c_in);

        // Sum bits at and above this group are still zero, so OR merges the slice in.
        assign w_s_nxt = w_s_in | (WIDTH'(w_grp[BLOCK-1:0]) << (k * BLOCK));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a <= '0;
                r_b <= '0;
                r_s <= '0;
                r_c <= 1'b0;
                r_v <= 1'b0;
            end else if (w_en) begin
                r_a <= w_a_in;
                r_b <= w_b_in;
                r_s <= w_s_nxt;
                r_c <= w_grp[BLOCK];
                r_v <= w_v_in;
            end
        end
    end

    logic w_top;
    logic w_unused_ops;

    // Sign-extension bit of the exact result: MSB operand bits plus final carry.
    assign w_top        = g_stage[L-1].r_a[WIDTH-1] ^ g_stage[L-1].r_b[WIDTH-1] ^ g_stage[L-1].r_c;
    assign w_unused_ops = ^{g_stage[L-1].r_a, g_stage[L-1].r_b};

    assign sum       = {w_top, g_stage[L-1].r_s};
    assign ovf       = w_top ^ g_stage[L-1].r_s[WIDTH-1];
    assign out_valid = g_stage[L-1].r_v;
    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;

endmodule
`default_nettype wire
